// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// type and access-size / legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  // Access size in bytes; illegal encodings report 4 so they never look small.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = 3'd1;
      F3_H, F3_HU: size_of = 3'd2;
      default:     size_of = 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and RAM port bundle of the load/store unit.
// The slave modport is the unit itself; master is the requester+RAM side.
interface load_store_unit_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [31:0]              req_wdata;
  logic                     resp_valid;
  logic [31:0]              resp_rdata;
  logic                     resp_err;
  logic                     ram_we;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [31:0]              ram_wdata;
  logic [31:0]              ram_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational data path of the load/store unit: load extraction with
// sign/zero extension and the read-modify-write merge for SB/SH.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  // Select/extend the addressed bytes and build the store merge word.
  always_comb begin
    load_data  = 32'h0000_0000;
    merge_data = word;
    case (funct3)
      F3_B: begin
        load_data  = {{24{word[7]}}, word[7:0]};
        merge_data = {word[31:8], wdata[7:0]};
      end
      F3_H: begin
        load_data  = {{16{word[15]}}, word[15:0]};
        merge_data = {word[31:16], wdata[15:0]};
      end
      F3_W: begin
        load_data  = word;
        merge_data = wdata;
      end
      F3_BU: begin
        load_data  = {24'h00_0000, word[7:0]};
        merge_data = word;
      end
      F3_HU: begin
        load_data  = {16'h0000, word[15:0]};
        merge_data = word;
      end
      default: begin
        load_data  = 32'h0000_0000;
        merge_data = word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit in front of a byte-addressed 32-bit RAM.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned H/W accesses into errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT  = 32'h0001FFFF
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);

  lsu_state_t               state_r;
  lsu_state_t               next_s;
  logic                     we_r;
  logic [2:0]               f3_r;
  logic [ADDRESS_WIDTH-1:0] addr_r;
  logic [31:0]              wdata_r;
  logic                     err_r;
  logic [31:0]              rdata_r;
  logic [31:0]              merge_r;

  logic                     accept_s;
  logic [ADDRESS_WIDTH:0]   last_s;
  logic                     range_s;
  logic                     mis_s;
  logic                     err_s;
  logic                     we_s;
  logic [31:0]              load_s;
  logic [31:0]              merge_s;

  assign accept_s = bus.req_valid && (state_r == IDLE) && !rst;

  // Last byte touched, one bit wider so a wrap past the top counts as out of range.
  assign last_s  = {1'b0, bus.req_addr}
                 + {{(ADDRESS_WIDTH-2){1'b0}}, size_of(bus.req_funct3)}
                 - {{ADDRESS_WIDTH{1'b0}}, 1'b1};
  assign range_s = last_s > {1'b0, ADDR_LIMIT};

  // Misalignment check on the incoming request.
  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    case (bus.req_funct3)
      F3_H, F3_HU: mis_s = bus.req_addr[0];
      F3_W:        mis_s = |bus.req_addr[1:0];
      default:     mis_s = 1'b0;
    endcase
`else
    mis_s = 1'b0;
`endif
  end

  assign err_s = !f3_legal(bus.req_we, bus.req_funct3) || range_s || mis_s;

  lsu_align u_align (
    .funct3     (f3_r),
    .word       (bus.ram_rdata),
    .wdata      (wdata_r),
    .load_data  (load_s),
    .merge_data (merge_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_s = err_s ? RESP : ACCESS;
        end else begin
          next_s = IDLE;
        end
      end
      ACCESS: begin
        if (we_r && (f3_r != F3_W)) begin
          next_s = WRITE;
        end else begin
          next_s = RESP;
        end
      end
      WRITE:   next_s = RESP;
      RESP:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Request capture, load result and store merge registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r    <= 1'b0;
      f3_r    <= 3'b000;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
      merge_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            we_r    <= bus.req_we;
            f3_r    <= bus.req_funct3;
            addr_r  <= bus.req_addr;
            wdata_r <= bus.req_wdata;
            err_r   <= err_s;
            rdata_r <= 32'h0000_0000;
          end
        end
        ACCESS: begin
          if (!we_r) begin
            rdata_r <= load_s;
          end else begin
            merge_r <= merge_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode; RAM write enable is suppressed during reset so an aborted write never lands.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'h0000_0000;
    bus.resp_err   = 1'b0;
    bus.ram_wdata  = 32'h0000_0000;
    we_s           = 1'b0;
    case (state_r)
      IDLE: begin
        bus.req_ready = !rst;
      end
      ACCESS: begin
        we_s          = we_r && (f3_r == F3_W);
        bus.ram_wdata = wdata_r;
      end
      WRITE: begin
        we_s          = 1'b1;
        bus.ram_wdata = merge_r;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_r;
        bus.resp_err   = err_r;
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
    if (rst) begin
      bus.ram_we = 1'b0;
    end else begin
      bus.ram_we = we_s;
    end
  end

  assign bus.ram_addr = addr_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset corner
// sequences and randomized requests against a byte-level reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int          AW    = 32;
  localparam logic [31:0] LIMIT = 32'h0001FFFF;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wcnt;
    logic [31:0] wword;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wcnt;
    logic [31:0] wword;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDRESS_WIDTH(AW)) bus ();

  load_store_unit #(.ADDRESS_WIDTH(AW), .ADDR_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Byte-addressed RAM model plus the reference model's own copy.
  bit [7:0]    mem     [0:LIMIT];
  bit [7:0]    ref_mem [0:LIMIT];
  logic        pl_we   = 1'b0;
  logic [31:0] pl_addr = 32'h0;
  logic [7:0]  pl_data = 8'h0;
  logic [32:0] ra;
  logic [31:0] rword;

  always_comb begin
    rword = 32'h0;
    ra    = 33'h0;
    for (int i = 0; i < 4; i++) begin
      ra = {1'b0, bus.ram_addr} + 33'(i);
      rword[i*8 +: 8] = (ra <= {1'b0, LIMIT}) ? mem[ra[31:0]] : 8'h00;
    end
  end
  assign bus.ram_rdata = rword;

  always @(posedge clk) begin
    if (bus.ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (({1'b0, bus.ram_addr} + 33'(i)) <= {1'b0, LIMIT})
          mem[bus.ram_addr + 32'(i)] <= bus.ram_wdata[i*8 +: 8];
      end
    end else if (pl_we) begin
      mem[pl_addr] <= pl_data;
    end
  end

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if ({32'h0, a} <= {32'h0, LIMIT}) return ref_mem[a];
    return 8'h00;
  endfunction

  // Reference: expected response from the architectural rules; applies stores to ref_mem.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          size;
    longint      last;
    logic        legal;
    logic        mis;
    logic [31:0] v;
    e.rdata = 32'h0; e.err = 1'b0; e.lat = 0; e.wcnt = 0; e.wword = 32'h0;
    if (we) legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else    legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    last = longint'({32'h0, addr}) + longint'(size) - 64'sd1;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = ((size == 2) && addr[0]) || ((size == 4) && (addr[1:0] != 2'b00));
`else
    mis = 1'b0;
`endif
    if (!legal || mis || (last > longint'({32'h0, LIMIT}))) begin
      e.err = 1'b1;
      e.lat = 1;
      return e;
    end
    if (!we) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[i*8 +: 8] = ref_byte(addr + 32'(i));
      if (!f3[2] && size < 4 && v[8*size-1])
        for (int i = size; i < 4; i++) v[i*8 +: 8] = 8'hFF;
      e.rdata = v;
      e.lat   = 2;
    end else begin
      for (int i = 0; i < 4; i++)
        e.wword[i*8 +: 8] = (i < size) ? wdata[i*8 +: 8] : ref_byte(addr + 32'(i));
      for (int i = 0; i < size; i++) ref_mem[addr + 32'(i)] = wdata[i*8 +: 8];
      e.lat  = (size < 4) ? 3 : 2;
      e.wcnt = 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
  endtask

  task automatic preload_done();
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // One request: accept, then count cycles to the response and record RAM writes.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output exp_t got);
    got.rdata = 32'h0; got.err = 1'b0; got.lat = 0; got.wcnt = 0; got.wword = 32'h0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    if (!bus.req_ready) got.lat = -1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.ram_we) begin
        got.wcnt++;
        got.wword = bus.ram_wdata;
      end
      if (bus.resp_valid) begin
        got.lat   = k;
        got.rdata = bus.resp_rdata;
        got.err   = bus.resp_err;
        break;
      end
    end
  endtask

  task automatic compare(input string tag, input exp_t got, input exp_t exp);
    chk({tag, ".latency"}, 32'(got.lat), 32'(exp.lat));
    chk({tag, ".err"}, {31'h0, got.err}, {31'h0, exp.err});
    chk({tag, ".rdata"}, got.rdata, exp.rdata);
    chk({tag, ".ram_we_cycles"}, 32'(got.wcnt), 32'(exp.wcnt));
    if (exp.wcnt != 0) chk({tag, ".ram_wdata"}, got.wword, exp.wword);
  endtask

  vec_t tbl[$];

  initial begin
    exp_t        got;
    exp_t        exp;
    exp_t        junk;
    int          seen;
    int          mism;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          sel;
    logic [2:0]  ld_set [5];
    logic [2:0]  st_set [3];

    ld_set = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_set = '{3'b000, 3'b001, 3'b010};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("reset.resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("reset.resp_rdata", bus.resp_rdata, 32'h0);
    chk("reset.resp_err", {31'h0, bus.resp_err}, 32'h0);
    chk("reset.ram_we", {31'h0, bus.ram_we}, 32'h0);
    chk("reset.ram_addr", bus.ram_addr, 32'h0);
    chk("reset.ram_wdata", bus.ram_wdata, 32'h0);

    preload(32'h100, 8'h80); preload(32'h101, 8'h7F);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h1FFFC, 8'h11); preload(32'h1FFFD, 8'h22);
    preload(32'h1FFFE, 8'h33); preload(32'h1FFFF, 8'h44);
    preload_done();

    //               we    f3      addr          wdata         rdata         err   lat wcnt wword
    tbl.push_back('{1'b0, 3'b000, 32'h00000100, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b100, 32'h00000100, 32'h0,        32'h00000080, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b001, 32'h00000102, 32'h0,        32'h00001234, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h00000100, 32'h0,        32'h12347F80, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b1, 3'b000, 32'h00000100, 32'hAABBCCDD, 32'h0,        1'b0, 3, 1, 32'h12347FDD});
    tbl.push_back('{1'b0, 3'b010, 32'h00000100, 32'h0,        32'h12347FDD, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h0001FFFE, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b010, 32'h0001FFFC, 32'h0,        32'h44332211, 1'b0, 2, 0, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
    tbl.push_back('{1'b0, 3'b001, 32'h00000101, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
`else
    tbl.push_back('{1'b0, 3'b001, 32'h00000101, 32'h0,        32'h0000347F, 1'b0, 2, 0, 32'h0});
`endif
    tbl.push_back('{1'b0, 3'b011, 32'h00000100, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
    tbl.push_back('{1'b1, 3'b100, 32'h00000100, 32'h12345678, 32'h0,        1'b1, 1, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b000, 32'h0001FFFF, 32'h0,        32'h00000044, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b001, 32'h0001FFFF, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b000, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1, 0, 32'h0});
    tbl.push_back('{1'b1, 3'b010, 32'h0001FFFC, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 3'b010, 32'h0001FFFC, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b001, 32'h0001FFFE, 32'h0,        32'hFFFFDEAD, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b101, 32'h0001FFFE, 32'h0,        32'h0000DEAD, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b1, 3'b001, 32'h00000102, 32'h12345566, 32'h0,        1'b0, 3, 1, 32'h00005566});
    tbl.push_back('{1'b0, 3'b010, 32'h00000100, 32'h0,        32'h55667FDD, 1'b0, 2, 0, 32'h0});
    tbl.push_back('{1'b0, 3'b000, 32'h00000101, 32'h0,        32'h0000007F, 1'b0, 2, 0, 32'h0});

    foreach (tbl[i]) begin
      run_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, got);
      exp.rdata = tbl[i].rdata; exp.err = tbl[i].err; exp.lat = tbl[i].lat;
      exp.wcnt = tbl[i].wcnt; exp.wword = tbl[i].wword;
      compare($sformatf("vec%0d", i), got, exp);
      junk = model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata);
    end

    // Reset during the WRITE cycle of an SH: nothing written, no response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
    bus.req_addr = 32'h100; bus.req_wdata = 32'h00009999;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstwr.in_write", {31'h0, bus.ram_we}, 32'h1);
    rst = 1'b1;
    #1 chk("rstwr.we_gated", {31'h0, bus.ram_we}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstwr.req_ready", {31'h0, bus.req_ready}, 32'h1);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.resp_valid) seen++;
      @(negedge clk);
    end
    chk("rstwr.no_resp", 32'(seen), 32'h0);
    mism = 0;
    for (int a = 32'h100; a < 32'h104; a++) if (mem[a] != ref_mem[a]) mism++;
    chk("rstwr.ram_unchanged", 32'(mism), 32'h0);

    // Request held during a reset cycle is not accepted.
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h100;
    @(posedge clk);
    #1 rst = 1'b0; bus.req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    chk("rstreq.not_accepted", 32'(seen), 32'h0);

    // Randomized traffic against the reference model.
    for (int a = 32'h100; a < 32'h144; a++) preload(32'(a), 8'($urandom));
    preload_done();
    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7)      addr = 32'h100 + $urandom_range(0, 60);
      else if (sel < 9) addr = 32'h1FFF0 + $urandom_range(0, 15);
      else              addr = $urandom;
      we    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we)                  f3 = st_set[$urandom_range(0, 2)];
      else                          f3 = ld_set[$urandom_range(0, 4)];
      exp = model(we, f3, addr, wdata);
      run_req(we, f3, addr, wdata, got);
      compare($sformatf("rnd%0d(we=%0d f3=%0d a=%08h)", n, we, f3, addr), got, exp);
    end

    mism = 0;
    for (int a = 32'h100; a < 32'h148; a++) if (mem[a] != ref_mem[a]) mism++;
    for (int a = 32'h1FFF0; a <= 32'h1FFFF; a++) if (mem[a] != ref_mem[a]) mism++;
    chk("final.ram_contents", 32'(mism), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the execute stage and the byte-addressed data RAM (32-bit little-endian read/write port, combinational read, write on rising clock). Accepts one RV32I load/store request at a time over a valid/ready handshake. Performs byte/halfword extraction with sign/zero extension for loads, and read-modify-write for SB/SH, because the RAM always writes 4 bytes. Returns a single-cycle response pulse carrying the load data or an error flag.

## Interface
- ADDRESS_WIDTH, 32, byte-address width on both request and RAM side
- ADDR_LIMIT, 32'h0001FFFF, highest legal byte address in the RAM
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDRESS_WIDTH  byte address
- req_wdata  in  32  store data; low bytes used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request rejected; valid only with resp_valid
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDRESS_WIDTH  RAM byte address
- ram_wdata  out  32  RAM write word
- ram_rdata  in  32  RAM read word; combinational from ram_addr

## Operation
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE: req_ready=1. On req_valid && req_ready, register we, funct3, addr and wdata, then evaluate errors.
  - Error: go to RESP with err_q=1. No RAM access in this case.
  - No error: go to ACCESS.
- Error conditions:
  - Illegal funct3: loads other than 000/001/010/100/101; stores other than 000/001/010.
  - Out of range: addr + size − 1 > ADDR_LIMIT. Compute in ADDRESS_WIDTH+1 bits so wrap past 2^ADDRESS_WIDTH counts as out of range.
- ACCESS: ram_addr = addr_q.
  - Load: extract the byte (ram_rdata[7:0]) or halfword ([15:0]) or the full word. Sign-extend for B/H, zero-extend for BU/HU. Store into rdata_q. Next state RESP.
  - SW: ram_we=1, ram_wdata=wdata_q. Next state RESP.
  - SB/SH: latch merge_q = ram_rdata with the low 8/16 bits replaced by wdata_q. Next state WRITE.
- WRITE: ram_we=1, ram_addr=addr_q, ram_wdata=merge_q. Next state RESP.
- RESP: resp_valid=1 with resp_rdata=rdata_q and resp_err=err_q. Next state IDLE.
- The response has no backpressure.
- req_ready=0 in every state except IDLE. Requests presented while busy are ignored and must be held by the requester.
- ram_we is 0 in IDLE and RESP, and is gated by !rst.
- ram_addr holds addr_q in every state.

## Timing
- Request accepted at edge N.
  - LW/LB/LBU/LH/LHU and SW: resp_valid high in cycle N+2.
  - SB/SH: resp_valid high in cycle N+3, with the RAM write at edge N+3.
  - Errors: resp_valid high in cycle N+1.
- Throughput: the next accept happens at the edge ending RESP. No back-to-back overlap.
- Reset values: state IDLE, req_ready 1 after reset, resp_valid 0, resp_rdata 0, resp_err 0, ram_we 0, ram_addr 0, ram_wdata 0.
- Reset mid-operation: state is IDLE at the next edge. A pending WRITE is abandoned, and the RAM is not written in the reset cycle. No response is issued for the aborted request.
- req_valid asserted in the reset cycle is not accepted.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - H/HU/SH with addr[0]≠0 is an error.
  - W/SW with addr[1:0]≠0 is an error.
  - Either case returns the error response after 1 cycle, with no RAM access.
- Undefined: misaligned accesses proceed normally. The RAM is byte-granular, so any address is served; the range check still applies.

## Structure
- lsu_pkg: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum lsu_state_t, and a size_of(funct3) function.
- Sub-module lsu_align (combinational): load extract/extend and store merge. Inputs: funct3, word, wdata.

## Test plan
- Reset then idle: req_ready=1, resp_valid=0, ram_we=0, all outputs 0.
- With RAM[0x100..0x103]=80 7F 34 12:
  - LB at 0x100 → resp_rdata 0xFFFFFF80.
  - LBU at 0x100 → resp_rdata 0x00000080.
  - LH at 0x102 → resp_rdata 0x00001234.
  - LW at 0x100 → resp_rdata 0x12347F80.
  - Each load responds 2 cycles after accept.
- SB 0xAABBCCDD at 0x100 over word 0x12347F80: ram_we high exactly one cycle with ram_wdata 0x12347FDD. resp_valid at N+3. A subsequent LW returns 0x12347FDD.
- LW at 0x1FFFE: resp_err=1 at N+1, ram_we never asserted. LW at 0x1FFFC succeeds.
- With LSU_MISALIGN_TRAP_EN, LH at 0x101 → resp_err=1. Without the macro → data from bytes 0x101/0x102. Illegal funct3 011 on a load → resp_err=1.
- Reset asserted during WRITE of an SH: no RAM byte changes, no resp_valid, req_ready=1 next cycle.
